priority_encoder_8_3_seq: RTL and testbench
===========================================

Name: priority_encoder_8_3_seq

Overview:
- Registered 8-to-3 priority encoder with sticky request capture and a valid/ack handshake. It is the encode direction of decoder_3_8.
- Active-low request lines are latched into a pending register.
- The highest-index pending request is presented as a 3-bit code {C,B,A} with V=1. The code is held until acknowledged.
- {C,B,A} connects directly to decoder_3_8 C/B/A, so a bench can round-trip encode -> decode.

Parameters:
- N_REQ, 8, number of request lines. Only 8 is supported; the parameter exists for documentation and lint.
- CODE_W, 3, code width, equal to clog2(N_REQ).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- I    input  8  request lines, active-low; I[7] has highest priority.
- EI   input  1  enable input, active-low. When EI=1, no new requests are latched.
- ack  input  1  consumer acknowledge, active-high, sampled on posedge clk.
- C    output 1  code bit 2 (MSB), registered.
- B    output 1  code bit 1, registered.
- A    output 1  code bit 0 (LSB), registered.
- V    output 1  code valid, registered, active-high.
- pending  output 8  current pending-request register, active-high, for observability.

Behaviour:
- Reset (rst=1, asynchronous): pending=8'h00, state=IDLE, {C,B,A}=3'b000, V=0. Reset asserted mid-PRESENT drops V immediately and discards all pending bits.
- Capture, each posedge: pending <= (pending & ~clr) | (EI==0 ? ~I : 8'h00).
  - clr is one-hot at index {C,B,A} when state=PRESENT and ack=1; otherwise clr=0.
  - If a bit is being set and cleared in the same cycle, set wins. A request held low therefore re-pends immediately after its ack.
- There is no combinational path from I, EI or ack to any output.
- State machine, two states:
  - IDLE: V=0. If pending != 0, load {C,B,A} <= index of the highest set bit of pending, set V <= 1, go to PRESENT. If pending == 0, stay in IDLE.
  - PRESENT: V=1 and {C,B,A} stable. There is no preemption: a higher-priority request that arrives while presenting waits in pending. On ack=1, clear that pending bit, set V <= 0, go to IDLE. On ack=0, hold.
- Latency:
  - A request sampled low at edge k sets pending at edge k; V=1 with the code is visible after edge k+1.
  - After an ack at edge m, V=0 for exactly one cycle (the IDLE bubble). The next code appears after edge m+1 if anything is pending.
- ack while in IDLE is ignored and has no side effects.
- EI=1: no new capture. Pending bits and the current presentation are retained and serviced normally.
- All-requests case: 8'hFF pending is serviced in order 7,6,...,0. This takes 8 grants, each separated by one bubble cycle.
- {C,B,A} holds its last value while V=0. Consumers must qualify the code with V.

Decomposition:
- Shared package, if the team's flow uses one: constants N_REQ=8 and CODE_W=3, plus state encodings IDLE=1'b0 and PRESENT=1'b1.
- One natural sub-module: prio_enc_8_3_comb, a purely combinational highest-set-bit finder. It maps 8 bits to a 3-bit index plus an any-set flag.
- The parent holds the pending register, the FSM and the output registers.

Test Plan:
1. Reset check: rst=1 mid-run with pending=8'h24, V=1 -> immediately V=0, {C,B,A}=000, pending=00. After release with I=8'hFF, V stays 0.
2. Single request: EI=0, I=8'hFB (bit 2 low) for one cycle, no ack -> pending=8'h04 after edge k. V=1 with {C,B,A}=010 after edge k+1, held for 5 cycles. Pulse ack -> V=0 and pending=00 next cycle. {C,B,A} into decoder_3_8 (G=1, G2A=G2B=0) gives Y with only bit 2 active.
3. Priority and no preemption: capture bits 1 and 5 together -> code 101. While presenting, pulse request bit 7 -> code stays 101 until ack. Then 111, then 001, each separated by a one-cycle V=0 bubble.
4. Enable gating: EI=1 with I=8'h00 -> pending stays 00 and V=0. Set EI=0 -> pending=FF. Acking every grant yields codes 7..0 in order, 8 grants total.
5. Held request and ack collision: keep I[3] low continuously and ack code 011 -> pending[3] remains 1, V=0 for one cycle, then 011 is presented again.
6. Random soak: 100 cycles of random I, EI and ack. A scoreboard model checks that {C,B,A} always equals the highest pending bit at grant time, the code never changes while V=1, and no request is lost.

Source files
------------

// File: rtl/priority_encoder_8_3_seq_pkg.sv
// Shared constants and FSM state encoding for the registered 8-to-3 priority encoder.
`default_nettype none

package priority_encoder_8_3_seq_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/prio_enc_8_3_comb.sv
// Combinational highest-set-bit finder: 8-bit vector to 3-bit index plus any-set flag.
`default_nettype none

module prio_enc_8_3_comb
  import priority_encoder_8_3_seq_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Ascending scan: the last hit, i.e. the highest set index, wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        idx = CODE_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/priority_encoder_8_3_seq.sv
// Registered 8-to-3 priority encoder with sticky active-low request capture and valid/ack handshake.
`default_nettype none

module priority_encoder_8_3_seq
  import priority_encoder_8_3_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] I,
  input  logic             EI,
  input  logic             ack,
  output logic             C,
  output logic             B,
  output logic             A,
  output logic             V,
  output logic [N_REQ-1:0] pending
);

  state_t              state;
  state_t              state_next;
  logic [CODE_W-1:0]   code;
  logic [CODE_W-1:0]   code_next;
  logic                valid_next;
  logic [N_REQ-1:0]    clr;
  logic [N_REQ-1:0]    set;
  logic [N_REQ-1:0]    pending_next;
  logic [CODE_W-1:0]   top_idx;
  logic                top_any;

  prio_enc_8_3_comb u_enc (
    .req (pending),
    .idx (top_idx),
    .any (top_any)
  );

  // Set is OR-ed in after the clear so a request held low re-pends right after its ack.
  always_comb begin
    clr = '0;
    if (state == PRESENT && ack) begin
      clr[code] = 1'b1;
    end
    set          = EI ? '0 : ~I;
    pending_next = (pending & ~clr) | set;
  end

  always_comb begin
    state_next = state;
    code_next  = code;
    valid_next = 1'b0;
    case (state)
      IDLE: begin
        if (top_any) begin
          state_next = PRESENT;
          code_next  = top_idx;
          valid_next = 1'b1;
        end
      end
      PRESENT: begin
        if (ack) begin
          state_next = IDLE;
        end else begin
          valid_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      code    <= '0;
      V       <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_next;
      code    <= code_next;
      V       <= valid_next;
      pending <= pending_next;
    end
  end

  assign C = code[2];
  assign B = code[1];
  assign A = code[0];

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_8_3_seq.sv
// Directed self-checking bench for priority_encoder_8_3_seq, with a short spec-model soak.
`default_nettype none

module tb_priority_encoder_8_3_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] I   = 8'hFF;
  logic       EI  = 1'b0;
  logic       ack = 1'b0;
  logic       C, B, A, V;
  logic [7:0] pending;
  logic [2:0] code;

  int n_cmp = 0;
  int n_err = 0;

  priority_encoder_8_3_seq dut (
    .clk     (clk),
    .rst     (rst),
    .I       (I),
    .EI      (EI),
    .ack     (ack),
    .C       (C),
    .B       (B),
    .A       (A),
    .V       (V),
    .pending (pending)
  );

  assign code = {C, B, A};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dec3_8(input logic [2:0] c);
    dec3_8 = 8'h01 << c;
  endfunction

  function automatic logic [2:0] highest(input logic [7:0] p);
    highest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (p[i]) return 3'(i);
    end
  endfunction

  // Cycle-level model of the specified behaviour, used by the soak.
  logic [7:0] m_pend;
  logic       m_state;
  logic [2:0] m_code;
  logic [7:0] m_clr;

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    #12;
    check("reset_v", {7'd0, V}, 8'h00);
    check("reset_code", {5'd0, code}, 8'h00);
    check("reset_pend", pending, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single request on bit 2, round-tripped through a 3-to-8 decode.
    I = 8'hFB;
    step();
    check("single_pend", pending, 8'h04);
    check("single_v_k", {7'd0, V}, 8'h00);
    I = 8'hFF;
    step();
    check("single_v", {7'd0, V}, 8'h01);
    check("single_code", {5'd0, code}, 8'h02);
    for (int i = 0; i < 4; i++) step();
    check("single_hold", {4'd0, V, code}, 8'h0A);
    check("single_dec", dec3_8(code), 8'h04);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("single_ack_v", {7'd0, V}, 8'h00);
    check("single_ack_pend", pending, 8'h00);

    // Priority, no preemption.
    I = 8'hDD;
    step();
    I = 8'hFF;
    check("prio_pend", pending, 8'h22);
    step();
    check("prio_code5", {4'd0, V, code}, 8'h0D);
    I = 8'h7F;
    step();
    I = 8'hFF;
    step();
    check("prio_nopre", {4'd0, V, code}, 8'h0D);
    check("prio_pend7", pending, 8'hA2);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("prio_bubble1", {4'd0, V, code}, 8'h05);
    check("prio_pend_a", pending, 8'h82);
    step();
    check("prio_code7", {4'd0, V, code}, 8'h0F);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("prio_bubble2", {7'd0, V}, 8'h00);
    step();
    check("prio_code1", {4'd0, V, code}, 8'h09);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("prio_done", {V, pending[6:0]}, 8'h00);

    // Enable gating then all-requests sweep.
    EI = 1'b1;
    I  = 8'h00;
    step();
    step();
    check("ei_block_pend", pending, 8'h00);
    check("ei_block_v", {7'd0, V}, 8'h00);
    EI = 1'b0;
    step();
    I = 8'hFF;
    check("ei_all_pend", pending, 8'hFF);
    for (int g = 7; g >= 0; g--) begin
      step();
      check($sformatf("sweep_grant%0d", g), {4'd0, V, code}, {4'd0, 1'b1, 3'(g)});
      ack = 1'b1;
      step();
      ack = 1'b0;
      check($sformatf("sweep_bubble%0d", g), {7'd0, V}, 8'h00);
    end
    check("sweep_empty", pending, 8'h00);

    // Held request colliding with its own ack.
    I = 8'hF7;
    step();
    step();
    check("held_code", {4'd0, V, code}, 8'h0B);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("held_repend", pending, 8'h08);
    check("held_bubble", {7'd0, V}, 8'h00);
    step();
    check("held_again", {4'd0, V, code}, 8'h0B);
    I = 8'hFF;
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("held_clear", pending, 8'h00);

    // Asynchronous reset while presenting.
    I = 8'hDB;
    step();
    I = 8'hFF;
    step();
    check("rst_pre", {4'd0, V, code}, 8'h0D);
    check("rst_pre_pend", pending, 8'h24);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_v", {7'd0, V}, 8'h00);
    check("rst_async_code", {5'd0, code}, 8'h00);
    check("rst_async_pend", pending, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("rst_after_v", {7'd0, V}, 8'h00);

    // Random soak against the model.
    m_pend  = 8'h00;
    m_state = 1'b0;
    m_code  = 3'd0;
    for (int n = 0; n < 100; n++) begin
      I   = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
      EI  = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 2) == 0);
      m_clr = (m_state && ack) ? dec3_8(m_code) : 8'h00;
      if (!m_state) begin
        if (m_pend != 8'h00) begin
          m_code  = highest(m_pend);
          m_state = 1'b1;
        end
      end else if (ack) begin
        m_state = 1'b0;
      end
      m_pend = (m_pend & ~m_clr) | (EI ? 8'h00 : ~I);
      step();
      check("soak_pend", pending, m_pend);
      check("soak_vcode", {4'd0, V, code}, {4'd0, m_state, m_code});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
